// File: rtl/rr_arbiter_if.sv
// Requester/arbiter handshake bundle for rr_arbiter.
// Ports: req/rel (W bits, driven by requesters), gnt (W, one-hot),
//        gnt_vld (1), gnt_idx ($clog2(W)), all driven by the arbiter.
interface rr_arbiter_if #(
   parameter int W = 4
);
   localparam int IW = $clog2(W);

   logic [W-1:0]  req;
   logic [W-1:0]  rel;
   logic [W-1:0]  gnt;
   logic          gnt_vld;
   logic [IW-1:0] gnt_idx;

   // requester side
   modport master (
      output req, rel,
      input  gnt, gnt_vld, gnt_idx
   );

   // arbiter side
   modport slave (
      input  req, rel,
      output gnt, gnt_vld, gnt_idx
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, release/drop handoff and hold timeout.
// Latency: 1 cycle from req (or end condition) to gnt; back-to-back handoff, no dead cycle.
// Backpressure: grantee holds until rel, req drop, or HOLD_MAX cycles while others wait.
// Ports: clk, rst_n (sync, active-low), bus (rr_arbiter_if.slave: req, rel in; gnt, gnt_vld, gnt_idx out).
module rr_arbiter #(
   parameter int W        = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arbiter_if.slave  bus
);
   localparam int IW = $clog2(W);
   localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);
   localparam logic [IW-1:0] LAST   = IW'(W - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  gnt_q, gnt_nxt;
   logic [IW-1:0] idx_q, idx_nxt;
   logic          vld_q;
   logic [IW-1:0] ptr, ptr_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic [IW-1:0] after_g;
   logic [IW-1:0] start;
   logic [2*W-1:0] rot2;
   logic          pick_vld;
   logic [IW-1:0] pick_idx;
   logic [W-1:0]  pick_oh;
   logic [IW:0]   sum;
   logic          req_g, rel_g, others, timeout, end_cond;

   // The grantee becomes lowest priority: scanning starts just past it.
   assign after_g = (idx_q == LAST) ? '0 : idx_q + IW'(1);
   assign start   = (state == GRANT) ? after_g : ptr;

   // Circular first-set-bit: rotate req so 'start' lands at bit 0, take the
   // lowest set bit, then map the offset back to an absolute index.
   always_comb begin
      rot2     = {bus.req, bus.req} >> start;
      pick_vld = 1'b0;
      pick_idx = '0;
      sum      = '0;
      for (int i = 0; i < W; i++) begin
         if (!pick_vld && rot2[i]) begin
            pick_vld = 1'b1;
            sum      = {1'b0, start} + (IW+1)'(i);
            if (sum >= (IW+1)'(W)) sum = sum - (IW+1)'(W);
            pick_idx = sum[IW-1:0];
         end
      end
      pick_oh = W'(1) << pick_idx;
   end

   // Masking with the one-hot grant restricts req/rel to the grantee only.
   assign req_g    = |(bus.req & gnt_q);
   assign rel_g    = |(bus.rel & gnt_q);
   assign others   = |(bus.req & ~gnt_q);
   assign timeout  = (HOLD_MAX != 0) && (cnt >= HOLD_C) && others;
   assign end_cond = !req_g || rel_g || timeout;

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      idx_nxt   = idx_q;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = GRANT;
               gnt_nxt   = pick_oh;
               idx_nxt   = pick_idx;
               cnt_nxt   = CW'(1);
            end
         end
         GRANT: begin
            if (end_cond) begin
               ptr_nxt = after_g;
               if (pick_vld) begin
                  gnt_nxt = pick_oh;
                  idx_nxt = pick_idx;
                  cnt_nxt = CW'(1);
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
                  idx_nxt   = '0;
                  cnt_nxt   = '0;
               end
            end else if (cnt < HOLD_C) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt_q <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         gnt_q <= gnt_nxt;
         idx_q <= idx_nxt;
         vld_q <= |gnt_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = idx_q;
   assign bus.gnt_vld = vld_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (W=4, HOLD_MAX=4): directed vectors plus a random phase.
// Stimulus pushes the expected grant per cycle; the monitor pops and compares
// at the falling edge, and also checks one-hot and starvation bounds.
module tb_rr_arbiter;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int LIMIT = (W - 1) * H + W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   rr_arbiter_if #(.W(W)) bus ();

   rr_arbiter #(.W(W), .HOLD_MAX(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   int wait_c[W];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
   endtask

   function automatic logic [31:0] oh2idx(input logic [W-1:0] v);
      for (int i = 0; i < W; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Monitor: inputs are changed 1 time unit after the falling edge, so here
   // req/rst_n still hold the values sampled at the preceding rising edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("gnt", 32'(bus.gnt), 32'(mon_e));
         chk("gnt_idx", 32'(bus.gnt_idx), oh2idx(mon_e));
         chk("gnt_vld", 32'(bus.gnt_vld), 32'(|mon_e));
      end
      chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      for (int i = 0; i < W; i++) begin
         if (!rst_n || !bus.req[i] || bus.gnt[i]) wait_c[i] = 0;
         else wait_c[i]++;
         chk("starve", 32'(wait_c[i] <= LIMIT), 32'd1);
      end
   end

   // Reference model for the random phase.
   logic [W-1:0] m_gnt = '0;
   int m_ptr = 0;
   int m_cnt = 0;

   function automatic logic [W-1:0] rr_pick(input logic [W-1:0] r, input int s);
      logic [W-1:0] o;
      o = '0;
      for (int i = 0; i < W; i++) begin
         if (r[(s + i) % W]) begin
            o[(s + i) % W] = 1'b1;
            return o;
         end
      end
      return o;
   endfunction

   task automatic model(input logic rn, input logic [W-1:0] rq, input logic [W-1:0] rl,
                        output logic [W-1:0] eg);
      int g;
      if (!rn) begin
         m_gnt = '0; m_ptr = 0; m_cnt = 0;
      end else if (m_gnt == '0) begin
         m_gnt = rr_pick(rq, m_ptr);
         m_cnt = (m_gnt != '0) ? 1 : 0;
      end else begin
         g = int'(oh2idx(m_gnt));
         if (!rq[g] || rl[g] || (m_cnt >= H && (rq & ~m_gnt) != '0)) begin
            m_ptr = (g + 1) % W;
            m_gnt = rr_pick(rq, m_ptr);
            m_cnt = (m_gnt != '0) ? 1 : 0;
         end else if (m_cnt < H) begin
            m_cnt++;
         end
      end
      eg = m_gnt;
   endtask

   task automatic step(input logic rn, input logic [W-1:0] rq, input logic [W-1:0] rl,
                       input logic [W-1:0] eg);
      rst_n   = rn;
      bus.req = rq;
      bus.rel = rl;
      exp_q.push_back(eg);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] rq, rl, eg;
      logic rn;
      bus.req = '0;
      bus.rel = '0;

      // reset state; rel while idle is ignored
      step(1'b0, 4'b0000, 4'b0000, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000, 4'b0000);
      chk("rst_ptr", 32'(dut.ptr), 32'd0);
      chk("rst_cnt", 32'(dut.cnt), 32'd0);
      step(1'b1, 4'b0000, 4'b1111, 4'b0000);

      // first grant from ptr 0, then drop hands off to the next requester
      step(1'b1, 4'b0110, 4'b0000, 4'b0010);
      step(1'b1, 4'b0100, 4'b0000, 4'b0100);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      // all requesting, grantee releases every cycle: full rotation, no gaps
      step(1'b0, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b1111, 4'b0000, 4'b0001);
      step(1'b1, 4'b1111, 4'b0001, 4'b0010);
      step(1'b1, 4'b1111, 4'b0010, 4'b0100);
      step(1'b1, 4'b1111, 4'b0100, 4'b1000);
      step(1'b1, 4'b1111, 4'b1000, 4'b0001);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      // timeout: 0001 held exactly H cycles while req[2] waits; rel[2] ignored
      step(1'b0, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b0001, 4'b0000, 4'b0001);
      step(1'b1, 4'b0101, 4'b0000, 4'b0001);
      step(1'b1, 4'b0101, 4'b0100, 4'b0001);
      step(1'b1, 4'b0101, 4'b0000, 4'b0001);
      step(1'b1, 4'b0101, 4'b0000, 4'b0100);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      // lone requester past HOLD_MAX: held, cnt saturates; rel regrants
      for (int i = 0; i < 20; i++) step(1'b1, 4'b1000, 4'b0000, 4'b1000);
      chk("cnt_sat", 32'(dut.cnt), 32'd4);
      step(1'b1, 4'b1000, 4'b1000, 4'b1000);
      chk("cnt_regrant", 32'(dut.cnt), 32'd1);
      chk("ptr_wrap", 32'(dut.ptr), 32'd0);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      // reset mid-grant with ptr = 3; restart from index 0
      step(1'b1, 4'b0100, 4'b0000, 4'b0100);
      step(1'b1, 4'b0100, 4'b0100, 4'b0100);
      chk("ptr_before_rst", 32'(dut.ptr), 32'd3);
      step(1'b0, 4'b0100, 4'b0000, 4'b0000);
      chk("ptr_after_rst", 32'(dut.ptr), 32'd0);
      step(1'b1, 4'b1100, 4'b0000, 4'b0100);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      // random req/rel against the reference model
      rq = '0;
      model(1'b0, 4'b0000, 4'b0000, eg);
      step(1'b0, 4'b0000, 4'b0000, eg);
      for (int c = 0; c < 3000; c++) begin
         rn = ($urandom_range(0, 399) != 0);
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            rl[b] = ($urandom_range(0, 5) == 0);
         end
         model(rn, rq, rl, eg);
         step(rn, rq, rl, eg);
      end

      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
